accumulation_buffer: RTL and testbench
======================================

ACCUMULATION_BUFFER -- requirements
Module: accumulation_buffer

Interface
REQ-001 SHALL have parameter OFMAP_WIDTH, default 32, width of each output-stationary lane value.
REQ-002 SHALL have parameter ARRAY_WIDTH, default 4, number of lanes (systolic array columns).
REQ-003 SHALL have parameter ACC_DEPTH, default 8, rows per bank; ADDR_WIDTH = $clog2(ACC_DEPTH).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 wr_en  input  1  accept one row of ofmap_in this cycle.
REQ-007 accumulate  input  1  1 = add to stored row, 0 = overwrite stored row.
REQ-008 ofmap_in  input  ARRAY_WIDTH x OFMAP_WIDTH signed  row from systolic array ofmap_out.
REQ-009 swap  input  1  single-cycle pulse exchanging write and read banks.
REQ-010 rd_en  input  1  read request.
REQ-011 rd_addr  input  ADDR_WIDTH  row index in read bank.
REQ-012 rd_data  output  ARRAY_WIDTH x OFMAP_WIDTH signed  registered read row.
REQ-013 rd_valid  output  1  rd_data holds the result of the previous-cycle rd_en.
REQ-014 wr_ptr  output  ADDR_WIDTH  next write row in write bank.
REQ-015 wr_bank  output  1  bank currently written; read bank is ~wr_bank.

Function
REQ-016 SHALL store 2 banks x ACC_DEPTH rows x ARRAY_WIDTH lanes of OFMAP_WIDTH signed registers.
REQ-017 On wr_en, row wr_ptr of bank wr_bank, lane i, SHALL become ofmap_in[i] (accumulate=0) or stored + ofmap_in[i] (accumulate=1), same edge.
REQ-018 Addition SHALL be two's-complement, OFMAP_WIDTH bits, wrap on overflow, no saturation.
REQ-019 On wr_en, wr_ptr SHALL increment; at ACC_DEPTH-1 it SHALL wrap to 0.
REQ-020 wr_ptr SHALL hold when wr_en=0.
REQ-021 On swap, wr_bank SHALL toggle and wr_ptr SHALL become 0 on the same edge.
REQ-022 swap with wr_en same cycle: write SHALL land in pre-swap bank at current wr_ptr; then swap takes effect (wr_ptr=0, not incremented).
REQ-023 On rd_en, rd_data SHALL load row rd_addr of bank ~wr_bank (pre-edge value), latency 1 cycle; rd_valid=1 next cycle.
REQ-024 rd_en with swap same cycle: read SHALL use pre-swap read bank.
REQ-025 rd_en=0: rd_valid SHALL be 0 next cycle; rd_data SHALL hold last value.
REQ-026 rd_addr >= ACC_DEPTH (non-power-of-2 depth): rd_data SHALL load zeros, rd_valid=1.
REQ-027 Reads never observe the write bank; no read/write collision case exists.

Reset
REQ-028 rst=1 SHALL immediately clear all storage, rd_data, rd_valid, wr_ptr, wr_bank to 0, independent of clk.
REQ-029 rst asserted mid-accumulation SHALL discard all partial sums; first edge after deassertion behaves as from power-up.
REQ-030 Inputs SHALL be ignored while rst=1.

Verification
REQ-031 Reset: rst pulse mid-run -> rd_data=0, rd_valid=0, wr_ptr=0, wr_bank=0 during reset, before next clk edge.
REQ-032 Overwrite+read: wr_en, accumulate=0, ofmap_in={90,100,110,120} then {202,228,254,280}; swap; rd_en rd_addr=0,1 -> rd_data {90,100,110,120} then {202,228,254,280}, rd_valid=1 each following cycle.
REQ-033 Accumulate: write {90,100,110,120} accumulate=0 at row 0, wrap ptr back to row 0 (ACC_DEPTH writes), write {202,228,254,280} accumulate=1 -> after swap row 0 reads {292,328,364,400}.
REQ-034 Wrap/overflow: stored 32'h7FFFFFFF + ofmap_in 1 with accumulate=1 -> 32'h80000000; wr_ptr sequence 7 -> 0.
REQ-035 Simultaneous swap+wr_en+rd_en: write goes to old bank row wr_ptr, read returns old read bank, wr_bank toggles, wr_ptr=0.
REQ-036 Ping-pong: fill bank 0, swap, fill bank 1 with distinct data while reading bank 0 every cycle -> bank 0 data unchanged on every read.

Source files
------------

// File: rtl/accumulation_buffer_if.sv
// accumulation_buffer_if: write/swap/read bus between a systolic array and its double-banked accumulation buffer.
interface accumulation_buffer_if #(
    parameter int OFMAP_WIDTH = 32,
    parameter int ARRAY_WIDTH = 4,
    parameter int ACC_DEPTH   = 8
);
    localparam int ADDR_WIDTH = ACC_DEPTH > 1 ? $clog2(ACC_DEPTH) : 1;
    logic                                    wr_en;
    logic                                    accumulate;
    logic [ARRAY_WIDTH-1:0][OFMAP_WIDTH-1:0] ofmap_in;
    logic                                    swap;
    logic                                    rd_en;
    logic [ADDR_WIDTH-1:0]                   rd_addr;
    logic [ARRAY_WIDTH-1:0][OFMAP_WIDTH-1:0] rd_data;
    logic                                    rd_valid;
    logic [ADDR_WIDTH-1:0]                   wr_ptr;
    logic                                    wr_bank;
    modport master (
        output wr_en, accumulate, ofmap_in, swap, rd_en, rd_addr,
        input  rd_data, rd_valid, wr_ptr, wr_bank
    );
    modport slave (
        input  wr_en, accumulate, ofmap_in, swap, rd_en, rd_addr,
        output rd_data, rd_valid, wr_ptr, wr_bank
    );
endinterface

// File: rtl/accumulation_buffer.sv
// accumulation_buffer: two banks of row registers; one bank overwrites or accumulates incoming rows
// while the other serves registered reads, and a swap pulse exchanges their roles.
module accumulation_buffer #(
    parameter int OFMAP_WIDTH = 32,
    parameter int ARRAY_WIDTH = 4,
    parameter int ACC_DEPTH   = 8
) (
    input logic clk,
    input logic rst,
    accumulation_buffer_if.slave bus
);
    localparam int ADDR_WIDTH = ACC_DEPTH > 1 ? $clog2(ACC_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(ACC_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(ACC_DEPTH);

    typedef logic [ARRAY_WIDTH-1:0][OFMAP_WIDTH-1:0] row_t;

    row_t                  mem_q [2][ACC_DEPTH];
    row_t                  mem_d [2][ACC_DEPTH];
    row_t                  rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic                  wr_bank_q, wr_bank_d;

    always_comb begin
        mem_d = mem_q;
        if (bus.wr_en)
            for (int i = 0; i < ARRAY_WIDTH; i++)
                mem_d[wr_bank_q][wr_ptr_q][i] =
                    (bus.accumulate ? mem_q[wr_bank_q][wr_ptr_q][i] : '0) + bus.ofmap_in[i];
        // swap wins over increment so a write in the swap cycle still lands at the old pointer
        wr_ptr_d   = bus.swap ? '0 : bus.wr_en ? (wr_ptr_q == LAST ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        wr_bank_d  = wr_bank_q ^ bus.swap;
        rd_valid_d = bus.rd_en;
        rd_data_d  = !bus.rd_en ? rd_data_q :
                     {1'b0, bus.rd_addr} < DEPTH ? mem_q[~wr_bank_q][bus.rd_addr] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q      <= '{default: '0};
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_ptr_q   <= '0;
            wr_bank_q  <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_bank_q  <= wr_bank_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.wr_ptr   = wr_ptr_q;
    assign bus.wr_bank  = wr_bank_q;
endmodule

// File: tb/tb_accumulation_buffer.sv
// tb_accumulation_buffer: directed and randomized checks of the accumulation buffer against
// a bank/row array model, plus a depth-6 instance for out-of-range reads.
module tb_accumulation_buffer;
    localparam int W = 32;
    localparam int N = 4;
    localparam int D = 8;
    typedef logic [N-1:0][W-1:0] row_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    accumulation_buffer_if #(.OFMAP_WIDTH(W), .ARRAY_WIDTH(N), .ACC_DEPTH(D)) bus ();
    accumulation_buffer #(.OFMAP_WIDTH(W), .ARRAY_WIDTH(N), .ACC_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    accumulation_buffer_if #(.OFMAP_WIDTH(W), .ARRAY_WIDTH(N), .ACC_DEPTH(6)) bus6 ();
    accumulation_buffer #(.OFMAP_WIDTH(W), .ARRAY_WIDTH(N), .ACC_DEPTH(6)) dut6 (
        .clk(clk), .rst(rst), .bus(bus6)
    );

    always #5 clk = ~clk;

    row_t m_mem [2][D];
    logic m_bank;
    int   m_ptr;
    row_t m_rd;
    logic m_valid;

    function automatic row_t mk(input int a, input int b, input int c, input int d);
        row_t r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    function automatic row_t rnd_row();
        row_t r;
        for (int i = 0; i < N; i++) r[i] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < D; a++) m_mem[b][a] = '0;
        m_bank = 0; m_ptr = 0; m_rd = '0; m_valid = 0;
    endtask

    task automatic idle();
        bus.wr_en = 0; bus.accumulate = 0; bus.ofmap_in = '0;
        bus.swap = 0; bus.rd_en = 0; bus.rd_addr = '0;
        bus6.wr_en = 0; bus6.accumulate = 0; bus6.ofmap_in = '0;
        bus6.swap = 0; bus6.rd_en = 0; bus6.rd_addr = '0;
    endtask

    // one clock edge; the model applies the pre-edge inputs with plain array arithmetic
    task automatic step();
        @(posedge clk);
        if (!rst) begin
            if (bus.rd_en) m_rd = m_mem[!m_bank][bus.rd_addr];
            m_valid = bus.rd_en;
            if (bus.wr_en)
                for (int i = 0; i < N; i++)
                    m_mem[m_bank][m_ptr][i] = (bus.accumulate ? m_mem[m_bank][m_ptr][i] : '0) + bus.ofmap_in[i];
            m_ptr = bus.swap ? 0 : bus.wr_en ? (m_ptr + 1) % D : m_ptr;
            if (bus.swap) m_bank = !m_bank;
        end
        #1;
    endtask

    task automatic wr(input row_t r, input logic acc);
        bus.wr_en = 1; bus.accumulate = acc; bus.ofmap_in = r;
        step();
        bus.wr_en = 0; bus.accumulate = 0;
    endtask

    task automatic rd(input int a);
        bus.rd_en = 1; bus.rd_addr = 3'(a);
        step();
        bus.rd_en = 0;
    endtask

    task automatic do_swap();
        bus.swap = 1;
        step();
        bus.swap = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        model_reset();
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        idle();
        model_reset();
        #1;
        n_checks++;
        if (bus.rd_data !== '0 || bus.rd_valid !== 0 || bus.wr_ptr !== 0 || bus.wr_bank !== 0) begin
            n_fail++;
            $display("FAIL reset_initial: rd_data=%h rd_valid=%b wr_ptr=%0d wr_bank=%b, required all zero",
                     bus.rd_data, bus.rd_valid, bus.wr_ptr, bus.wr_bank);
        end
        step();
        rst = 0;
        for (int i = 0; i < 3; i++) wr(rnd_row(), 0);
        do_swap();
        rd(0);
        n_checks++;
        if (bus.rd_data !== m_rd || bus.rd_valid !== 1) begin
            n_fail++;
            $display("FAIL reset_preread: rd_data=%h valid=%b, required %h valid 1", bus.rd_data, bus.rd_valid, m_rd);
        end
        wr(rnd_row(), 0);
        #2 rst = 1;
        model_reset();
        #1;
        n_checks++;
        if (bus.rd_data !== '0 || bus.rd_valid !== 0 || bus.wr_ptr !== 0 || bus.wr_bank !== 0) begin
            n_fail++;
            $display("FAIL reset_async: rd_data=%h rd_valid=%b wr_ptr=%0d wr_bank=%b, required all zero",
                     bus.rd_data, bus.rd_valid, bus.wr_ptr, bus.wr_bank);
        end
        bus.wr_en = 1; bus.ofmap_in = rnd_row(); bus.swap = 1;
        step();
        idle();
        rst = 0;
        n_checks++;
        if (bus.wr_ptr !== 0 || bus.wr_bank !== 0) begin
            n_fail++;
            $display("FAIL reset_ignores_inputs: wr_ptr=%0d wr_bank=%b, required 0 0", bus.wr_ptr, bus.wr_bank);
        end
        do_swap();
        rd(0);
        n_checks++;
        if (bus.rd_data !== '0 || bus.rd_valid !== 1) begin
            n_fail++;
            $display("FAIL reset_cleared_storage: rd_data=%h valid=%b, required 0 valid 1", bus.rd_data, bus.rd_valid);
        end
    endtask

    task automatic test_overwrite_read();
        do_reset();
        wr(mk(90, 100, 110, 120), 0);
        wr(mk(202, 228, 254, 280), 0);
        do_swap();
        rd(0);
        n_checks++;
        if (bus.rd_data !== mk(90, 100, 110, 120) || bus.rd_valid !== 1) begin
            n_fail++;
            $display("FAIL overwrite_row0: rd_data=%h valid=%b, required %h valid 1", bus.rd_data, bus.rd_valid, mk(90, 100, 110, 120));
        end
        rd(1);
        n_checks++;
        if (bus.rd_data !== mk(202, 228, 254, 280) || bus.rd_valid !== 1) begin
            n_fail++;
            $display("FAIL overwrite_row1: rd_data=%h valid=%b, required %h valid 1", bus.rd_data, bus.rd_valid, mk(202, 228, 254, 280));
        end
        step();
        n_checks++;
        if (bus.rd_data !== mk(202, 228, 254, 280) || bus.rd_valid !== 0) begin
            n_fail++;
            $display("FAIL read_hold: rd_data=%h valid=%b, required %h valid 0", bus.rd_data, bus.rd_valid, mk(202, 228, 254, 280));
        end
    endtask

    task automatic test_accumulate();
        do_reset();
        wr(mk(90, 100, 110, 120), 0);
        for (int i = 0; i < D - 1; i++) wr(rnd_row(), 0);
        n_checks++;
        if (bus.wr_ptr !== 0) begin
            n_fail++;
            $display("FAIL acc_ptr_wrap: wr_ptr=%0d, required 0", bus.wr_ptr);
        end
        wr(mk(202, 228, 254, 280), 1);
        n_checks++;
        if (bus.wr_ptr !== 1) begin
            n_fail++;
            $display("FAIL acc_ptr_inc: wr_ptr=%0d, required 1", bus.wr_ptr);
        end
        do_swap();
        rd(0);
        n_checks++;
        if (bus.rd_data !== mk(292, 328, 364, 400) || bus.rd_valid !== 1) begin
            n_fail++;
            $display("FAIL acc_sum: rd_data=%h valid=%b, required %h valid 1", bus.rd_data, bus.rd_valid, mk(292, 328, 364, 400));
        end
    endtask

    task automatic test_overflow();
        do_reset();
        wr({N{32'h7FFFFFFF}}, 0);
        for (int i = 0; i < D - 2; i++) wr(rnd_row(), 0);
        n_checks++;
        if (bus.wr_ptr !== 7) begin
            n_fail++;
            $display("FAIL ovf_ptr7: wr_ptr=%0d, required 7", bus.wr_ptr);
        end
        wr(rnd_row(), 0);
        n_checks++;
        if (bus.wr_ptr !== 0) begin
            n_fail++;
            $display("FAIL ovf_ptr_wrap: wr_ptr=%0d, required 0", bus.wr_ptr);
        end
        wr({N{32'h1}}, 1);
        do_swap();
        rd(0);
        n_checks++;
        if (bus.rd_data !== {N{32'h80000000}}) begin
            n_fail++;
            $display("FAIL ovf_wrap_sum: rd_data=%h, required %h", bus.rd_data, {N{32'h80000000}});
        end
    endtask

    task automatic test_simultaneous();
        row_t r;
        for (int i = 0; i < 3; i++) wr(rnd_row(), 0);
        r = rnd_row();
        bus.wr_en = 1; bus.ofmap_in = r; bus.swap = 1; bus.rd_en = 1; bus.rd_addr = 3'd0;
        step();
        idle();
        n_checks++;
        if (bus.rd_data !== {N{32'h80000000}} || bus.rd_valid !== 1 || bus.wr_bank !== 0 || bus.wr_ptr !== 0) begin
            n_fail++;
            $display("FAIL simul_swap: rd_data=%h valid=%b wr_bank=%b wr_ptr=%0d, required %h 1 0 0",
                     bus.rd_data, bus.rd_valid, bus.wr_bank, bus.wr_ptr, {N{32'h80000000}});
        end
        rd(3);
        n_checks++;
        if (bus.rd_data !== r) begin
            n_fail++;
            $display("FAIL simul_write_old_bank: rd_data=%h, required %h", bus.rd_data, r);
        end
    endtask

    task automatic test_ping_pong();
        row_t b0 [D];
        do_reset();
        for (int i = 0; i < D; i++) begin
            b0[i] = rnd_row();
            wr(b0[i], 0);
        end
        do_swap();
        for (int i = 0; i < D; i++) begin
            bus.wr_en = 1; bus.ofmap_in = rnd_row(); bus.accumulate = 1'($urandom);
            bus.rd_en = 1; bus.rd_addr = 3'(i);
            step();
            n_checks++;
            if (bus.rd_data !== b0[i] || bus.rd_valid !== 1) begin
                n_fail++;
                $display("FAIL ping_pong_row%0d: rd_data=%h valid=%b, required %h valid 1", i, bus.rd_data, bus.rd_valid, b0[i]);
            end
        end
        idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.wr_en = 1'($urandom); bus.accumulate = 1'($urandom); bus.ofmap_in = rnd_row();
            bus.swap = ($urandom_range(0, 7) == 0); bus.rd_en = 1'($urandom); bus.rd_addr = 3'($urandom);
            step();
            n_checks++;
            if (bus.rd_data !== m_rd || bus.rd_valid !== m_valid || bus.wr_ptr !== 3'(m_ptr) || bus.wr_bank !== m_bank) begin
                n_fail++;
                $display("FAIL random_cycle%0d: rd_data=%h valid=%b ptr=%0d bank=%b, required %h %b %0d %b",
                         c, bus.rd_data, bus.rd_valid, bus.wr_ptr, bus.wr_bank, m_rd, m_valid, m_ptr, m_bank);
            end
        end
        idle();
    endtask

    task automatic test_out_of_range();
        bus6.wr_en = 1; bus6.ofmap_in = mk(5, 6, 7, 8);
        step();
        bus6.wr_en = 0; bus6.swap = 1;
        step();
        bus6.swap = 0; bus6.rd_en = 1; bus6.rd_addr = 3'd0;
        step();
        n_checks++;
        if (bus6.rd_data !== mk(5, 6, 7, 8) || bus6.rd_valid !== 1) begin
            n_fail++;
            $display("FAIL oob_inrange: rd_data=%h valid=%b, required %h valid 1", bus6.rd_data, bus6.rd_valid, mk(5, 6, 7, 8));
        end
        for (int a = 6; a < 8; a++) begin
            bus6.rd_addr = 3'(a);
            step();
            n_checks++;
            if (bus6.rd_data !== '0 || bus6.rd_valid !== 1) begin
                n_fail++;
                $display("FAIL oob_addr%0d: rd_data=%h valid=%b, required 0 valid 1", a, bus6.rd_data, bus6.rd_valid);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_overwrite_read();
        test_accumulate();
        test_overflow();
        test_simultaneous();
        test_ping_pong();
        test_random();
        test_out_of_range();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
